gray_cntr_updn: RTL and testbench

Parametrised W-bit Gray-code counter: the next-generation counter primitive for the LAB counter set, generalised in width and extended with up/down counting, parallel load, synchronous clear and a wrap/saturate mode. It keeps the clock-enable cascade outputs (TC, CEO) so that several instances chain into wider counters. A registered binary shadow output is also provided. Typical use is as a pointer or sequence generator where only one bit may change per count step.

---
 rtl/gray_cntr_updn_if.sv | 26 ++
 rtl/gray_cntr_updn.sv | 72 +++++++
 tb/tb_gray_cntr_updn.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/gray_cntr_updn_if.sv
// Control and data bundle for one gray_cntr_updn stage.
//   master: drives ce, dn, clr, ld, D; observes Q, B, TC, CEO
//   slave : the counter itself
interface gray_cntr_updn_if #(
    parameter int unsigned W = 4
);
    logic         ce;   // count enable
    logic         dn;   // 0 = up, 1 = down
    logic         clr;  // synchronous clear to code 0
    logic         ld;   // synchronous load of D
    logic [W-1:0] D;    // Gray-coded load value
    logic [W-1:0] Q;    // registered Gray count
    logic [W-1:0] B;    // registered binary count
    logic         TC;   // terminal count for current direction (comb)
    logic         CEO;  // cascade enable, ce & TC (comb)

    modport master (
        output ce, dn, clr, ld, D,
        input  Q, B, TC, CEO
    );

    modport slave (
        input  ce, dn, clr, ld, D,
        output Q, B, TC, CEO
    );
endinterface

// File: rtl/gray_cntr_updn.sv
// W-bit up/down Gray-code counter with load, clear and wrap/saturate.
// Ports:
//   clk - rising-edge clock
//   r   - asynchronous active-low reset
//   bus - gray_cntr_updn_if slave: ce, dn, clr, ld, D in; Q, B, TC, CEO out
// Q and B come straight from flops; TC and CEO are combinational from
// the count register plus dn/ce so stages can be chained via CEO -> ce.
module gray_cntr_updn #(
    parameter int unsigned W    = 4,
    parameter bit          WRAP = 1'b1
) (
    input  logic             clk,
    input  logic             r,
    gray_cntr_updn_if.slave  bus
);

    localparam logic [W-1:0] CNT_MAX = '1;
    localparam logic [W-1:0] CNT_ONE = W'(1);

    logic [W-1:0] cnt;
    logic [W-1:0] cnt_nxt;
    logic [W-1:0] q_reg;
    logic [W-1:0] ld_bin;
    logic         tc;

    // Gray-to-binary of the load value: prefix XOR from the MSB down.
    always_comb begin
        ld_bin        = '0;
        ld_bin[W-1]   = bus.D[W-1];
        for (int i = int'(W) - 2; i >= 0; i--) begin
            ld_bin[i] = ld_bin[i+1] ^ bus.D[i];
        end
    end

    // Terminal count depends on direction only, no pipeline.
    always_comb begin
        tc = bus.dn ? (cnt == '0) : (cnt == CNT_MAX);
    end

    // Next count: clr > ld > count step; load ignores ce.
    always_comb begin
        cnt_nxt = cnt;
        if (bus.clr) begin
            cnt_nxt = '0;
        end else if (bus.ld) begin
            cnt_nxt = ld_bin;
        end else if (bus.ce) begin
            if (!tc) begin
                cnt_nxt = bus.dn ? (cnt - CNT_ONE) : (cnt + CNT_ONE);
            end else if (WRAP) begin
                cnt_nxt = bus.dn ? CNT_MAX : '0;
            end
        end
    end

    // Gray code is formed before the flop so Q has no output decode.
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            cnt   <= '0;
            q_reg <= '0;
        end else begin
            cnt   <= cnt_nxt;
            q_reg <= cnt_nxt ^ (cnt_nxt >> 1);
        end
    end

    assign bus.Q   = q_reg;
    assign bus.B   = cnt;
    assign bus.TC  = tc;
    assign bus.CEO = bus.ce & tc;

endmodule

// File: tb/tb_gray_cntr_updn.sv
// Directed bench for gray_cntr_updn: wrap and saturate W=4 instances plus
// a two-stage W=3 cascade.
module tb_gray_cntr_updn;

    logic clk;
    logic r;

    int errors;
    int checks;

    gray_cntr_updn_if #(.W(4)) bw ();
    gray_cntr_updn_if #(.W(4)) bs ();
    gray_cntr_updn_if #(.W(3)) blo ();
    gray_cntr_updn_if #(.W(3)) bhi ();

    gray_cntr_updn #(.W(4), .WRAP(1'b1)) u_wrap (.clk(clk), .r(r), .bus(bw.slave));
    gray_cntr_updn #(.W(4), .WRAP(1'b0)) u_sat  (.clk(clk), .r(r), .bus(bs.slave));
    gray_cntr_updn #(.W(3), .WRAP(1'b1)) u_lo   (.clk(clk), .r(r), .bus(blo.slave));
    gray_cntr_updn #(.W(3), .WRAP(1'b1)) u_hi   (.clk(clk), .r(r), .bus(bhi.slave));

    // Cascade: upper stage enabled by lower stage CEO, shared direction.
    assign bhi.ce = blo.CEO;
    assign bhi.dn = blo.dn;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] gseq [16];
    logic [3:0] prev_q;
    logic [2:0] prev_hi;
    int         hi_adv;

    initial begin
        gseq = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                 4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
        errors = 0;
        checks = 0;
        r = 1'b0;
        bw.ce = 1'b0; bw.dn = 1'b0; bw.clr = 1'b0; bw.ld = 1'b0; bw.D = '0;
        bs.ce = 1'b0; bs.dn = 1'b0; bs.clr = 1'b0; bs.ld = 1'b0; bs.D = '0;
        blo.ce = 1'b0; blo.dn = 1'b0; blo.clr = 1'b0; blo.ld = 1'b0; blo.D = '0;
        bhi.clr = 1'b0; bhi.ld = 1'b0; bhi.D = '0;

        // Reset state
        repeat (2) step();
        check("rst_q", 16'(bw.Q), 16'h0);
        check("rst_b", 16'(bw.B), 16'h0);
        check("rst_tc", 16'(bw.TC), 16'h0);
        bw.dn = 1'b1;
        #1;
        check("rst_tc_dn", 16'(bw.TC), 16'h1);
        bw.dn = 1'b0;

        // Full up count with wrap
        r = 1'b1;
        bw.ce = 1'b1;
        #1;
        for (int k = 0; k < 16; k++) begin
            check("up_tc", 16'(bw.TC), 16'(k == 15));
            check("up_ceo", 16'(bw.CEO), 16'(k == 15));
            prev_q = bw.Q;
            step();
            check("up_q", 16'(bw.Q), 16'(gseq[(k + 1) % 16]));
            check("up_onebit", 16'($countones(prev_q ^ bw.Q)), 16'h1);
        end

        // Down count and wrap from 0
        bw.dn = 1'b1;
        #1;
        check("dn_tc0", 16'(bw.TC), 16'h1);
        check("dn_ceo0", 16'(bw.CEO), 16'h1);
        step();
        check("dn_wrap_q", 16'(bw.Q), 16'h8);
        check("dn_wrap_b", 16'(bw.B), 16'd15);
        step();
        check("dn_q", 16'(bw.Q), 16'h9);
        check("dn_b", 16'(bw.B), 16'd14);
        bw.ce = 1'b0;

        // Saturate mode
        bs.ce = 1'b1;
        repeat (15) step();
        check("sat_reach_q", 16'(bs.Q), 16'h8);
        for (int k = 0; k < 3; k++) begin
            check("sat_ceo", 16'(bs.CEO), 16'h1);
            step();
            check("sat_hold_q", 16'(bs.Q), 16'h8);
        end
        bs.dn = 1'b1;
        #1;
        check("sat_dn_tc", 16'(bs.TC), 16'h0);
        step();
        check("sat_dn_q", 16'(bs.Q), 16'h9);
        check("sat_dn_b", 16'(bs.B), 16'd14);
        bs.ce = 1'b0;

        // Load and priority
        bw.ce = 1'b1; bw.ld = 1'b1; bw.D = 4'b0110;
        step();
        check("ld_q", 16'(bw.Q), 16'h6);
        check("ld_b", 16'(bw.B), 16'd4);
        bw.ce = 1'b0; bw.D = 4'b1111;
        step();
        check("ld_ff_q", 16'(bw.Q), 16'hF);
        check("ld_ff_b", 16'(bw.B), 16'd10);
        bw.ce = 1'b1; bw.clr = 1'b1;
        step();
        check("clr_ld_q", 16'(bw.Q), 16'h0);
        check("clr_ld_b", 16'(bw.B), 16'h0);
        bw.ce = 1'b0; bw.clr = 1'b0; bw.ld = 1'b0;
        repeat (2) step();
        check("hold_q", 16'(bw.Q), 16'h0);

        // Asynchronous reset between edges
        bw.ld = 1'b1; bw.D = 4'b0101;
        step();
        check("pre_arst_q", 16'(bw.Q), 16'h5);
        check("pre_arst_b", 16'(bw.B), 16'd6);
        bw.ld = 1'b0; bw.ce = 1'b1; bw.dn = 1'b0;
        #3;
        r = 1'b0;
        #1;
        check("arst_q", 16'(bw.Q), 16'h0);
        check("arst_b", 16'(bw.B), 16'h0);
        #1;
        r = 1'b1;
        step();
        check("post_arst_q", 16'(bw.Q), 16'h1);
        bw.ce = 1'b0;

        // Two-stage cascade, 6 bits total
        blo.ce = 1'b1;
        hi_adv = 0;
        #1;
        for (int c = 0; c < 64; c++) begin
            check("casc_ceo", 16'(bhi.CEO), 16'(c == 63));
            prev_hi = bhi.B;
            step();
            if (bhi.B != prev_hi) hi_adv++;
        end
        check("casc_adv", 16'(hi_adv), 16'd8);
        check("casc_lo_q", 16'(blo.Q), 16'h0);
        check("casc_hi_q", 16'(bhi.Q), 16'h0);
        blo.ce = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
